// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic MDU_MULT = 1'b0;
    localparam logic MDU_DIV  = 1'b1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [1:0] DZ   = 2'd3;

    // Wide enough for a 2*WIDTH product at any practical WIDTH; callers cast in and out.
    localparam int unsigned MDU_NEG_W = 256;

    function automatic logic [MDU_NEG_W-1:0] mdu_negate(input logic [MDU_NEG_W-1:0] v,
                                                        input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_out
);

    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   diff;

    always_comb begin
        upper   = acc_in[2*WIDTH:WIDTH];
        lower   = acc_in[WIDTH-1:0];
        sum     = upper;
        rem     = '0;
        diff    = '0;
        acc_out = '0;
        if (mode == MDU_MULT) begin
            if (lower[0]) begin
                sum = upper + {1'b0, operand};
            end
            acc_out = {1'b0, sum, lower[WIDTH-1:1]};
        end else begin
            // Remainder lives in the upper half, quotient bits shift in at the bottom.
            rem  = {upper[WIDTH-1:0], lower[WIDTH-1]};
            diff = rem - {1'b0, operand};
            if (rem >= {1'b0, operand}) begin
                acc_out = {diff, lower[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {rem, lower[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide engine with start/done handshake
// writing HI/LO; raises div0 on division by zero.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    logic               neg_q;      // product or quotient sign
    logic               neg_r_q;    // remainder sign
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   opnd_q;

    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode    (op_q),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (acc_step)
    );

    always_comb begin
        abs_a    = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b    = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
        prod_fin = (2*WIDTH)'(mdu_negate(MDU_NEG_W'(acc_q[2*WIDTH-1:0]), neg_q));
        quot_fin = WIDTH'(mdu_negate(MDU_NEG_W'(acc_q[WIDTH-1:0]), neg_q));
        rem_fin  = WIDTH'(mdu_negate(MDU_NEG_W'(acc_q[2*WIDTH-1:WIDTH]), neg_r_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped, not queued.
                    if (start && !done) begin
                        op_q    <= op;
                        neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_q <= sgn & a[WIDTH-1];
                        acc_q   <= {{(WIDTH+1){1'b0}}, abs_a};
                        opnd_q  <= abs_b;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= (op == MDU_DIV && b == '0) ? DZ : RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    if (op_q == MDU_MULT) begin
                        hi <= prod_fin[2*WIDTH-1:WIDTH];
                        lo <= prod_fin[WIDTH-1:0];
                    end else begin
                        hi <= rem_fin;
                        lo <= quot_fin;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                DZ: begin
                    done    <= 1'b1;
                    div0    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
